// File: rtl/spi_master_cs.sv
// SPI mode-0 master that runs one DATA_W-bit MSB-first full-duplex transfer.
// It drives the one-hot active-low chip select, sclk and mosi, and samples the shared miso line.
module spi_master_cs #(
  parameter int unsigned NSLAVE  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NSLAVE)-1:0] slave_sel,
  input  logic [DATA_W-1:0]         tx_data,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NSLAVE-1:0]         cs_decode
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]  r_tx;
  logic [DATA_W-1:0]  r_rx;
  logic [DATA_W-1:0]  r_rx_data;
  logic [NSLAVE-1:0]  r_cs;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_busy;
  logic               r_done;

  logic               w_sel_ok;
  logic               w_div_end;

  assign w_sel_ok  = (32'(slave_sel) < NSLAVE);
  assign w_div_end = (r_div == DIV_LAST);

  // Sequencer: every sclk phase lasts CLK_DIV cycles; miso is captured on the rising-edge transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cs      <= '1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_sel_ok) begin
            r_tx    <= tx_data;
            r_cs    <= ~(NSLAVE'(1) << slave_sel);
            r_mosi  <= tx_data[DATA_W-1];
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[DATA_W-2:0], miso};
            r_bit   <= r_bit + BIT_W'(1);
            r_state <= S_SHIFT_HI;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT_HI: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_state <= S_SHIFT_LO;
            // Present the next lower bit; after the last bit, mosi keeps the LSB.
            if (r_bit != BIT_ALL) begin
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
              r_mosi <= r_tx[DATA_W-2];
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT_LO: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_bit == BIT_ALL) begin
              r_state <= S_HOLD;
            end else begin
              r_sclk  <= 1'b1;
              r_rx    <= {r_rx[DATA_W-2:0], miso};
              r_bit   <= r_bit + BIT_W'(1);
              r_state <= S_SHIFT_HI;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div     <= '0;
            r_cs      <= '1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_state   <= S_IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rx_data   = r_rx_data;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_decode = r_cs;

endmodule

// File: tb/tb_spi_master_cs.sv
// Randomized scoreboard bench for spi_master_cs: a default instance with a slave shift model,
// and a CLK_DIV=1 / DATA_W=16 / NSLAVE=3 instance with miso looped back from mosi.
module tb_spi_master_cs;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] tx;
    logic [31:0] cs;
    longint      t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 0: defaults
  logic       rst0 = 1'b1, start0 = 1'b0;
  logic [1:0] sel0 = '0;
  logic [7:0] tx0 = '0, rx0;
  logic       busy0, done0, sclk0, mosi0, miso0;
  logic [3:0] cs0;

  // Instance 1: CLK_DIV=1, DATA_W=16, NSLAVE=3
  logic        rst1 = 1'b1, start1 = 1'b0;
  logic [1:0]  sel1 = '0;
  logic [15:0] tx1 = '0, rx1;
  logic        busy1, done1, sclk1, mosi1, miso1;
  logic [2:0]  cs1;

  spi_master_cs u0 (
    .clk(clk), .rst(rst0), .start(start0), .slave_sel(sel0), .tx_data(tx0),
    .busy(busy0), .done(done0), .rx_data(rx0), .sclk(sclk0), .mosi(mosi0),
    .miso(miso0), .cs_decode(cs0)
  );

  spi_master_cs #(.NSLAVE(3), .DATA_W(16), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .slave_sel(sel1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1),
    .miso(miso1), .cs_decode(cs1)
  );

  assign miso1 = mosi1;

  exp_t       exp0_q[$];
  exp_t       exp1_q[$];
  logic [7:0] slave_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Slave for instance 0: shifts its word MSB first, advancing after each sclk fall.
  logic [7:0] s_word = '0;
  int         s_idx = 0;
  logic       s_prev_sclk = 1'b0, s_prev_idle = 1'b1, noise = 1'b0;
  always @(posedge clk) begin
    noise <= 1'($urandom);
    if (cs0 == 4'hF) s_idx <= 0;
    else begin
      if (s_prev_idle && slave_q.size() > 0) s_word <= slave_q.pop_front();
      if (s_prev_sclk && !sclk0) s_idx <= s_idx + 1;
    end
    s_prev_sclk <= sclk0;
    s_prev_idle <= (cs0 == 4'hF);
  end
  assign miso0 = (cs0 != 4'hF && s_idx < 8) ? s_word[3'(7 - s_idx)] : noise;

  // Monitor 0
  int         rises0 = 0, cslow0 = 0, csbad0 = 0;
  logic [7:0] acc0 = '0;
  logic       prev_sclk0 = 1'b0, flush0 = 1'b0;
  longint     tf0 = 0, tl0 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (flush0) begin
      rises0 = 0; cslow0 = 0; csbad0 = 0; acc0 = '0; flush0 = 1'b0;
    end
    if (done0) begin
      chk("done0_expected", {31'd0, exp0_q.size() != 0}, 32'd1);
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        chk("rx0", 32'(rx0), 32'(e.rx[7:0]));
        chk("mosi0_bits", 32'(acc0), 32'(e.tx[7:0]));
        chk("rises0", rises0, 32'd8);
        chk("cs0_low_cycles", cslow0, 32'd72);
        chk("cs0_bad_cycles", csbad0, 32'd0);
        chk("done0_time", 32'($time), 32'(e.t));
        chk("busy0_at_done", 32'(busy0), 32'd0);
        chk("sclk0_span", 32'(tl0 - tf0), 32'd560);
      end
      rises0 = 0; cslow0 = 0; csbad0 = 0; acc0 = '0;
    end
    if (cs0 != 4'hF) begin
      cslow0++;
      if (exp0_q.size() == 0 || cs0 != exp0_q[0].cs[3:0]) csbad0++;
    end
    if (sclk0 && !prev_sclk0) begin
      if (rises0 == 0) tf0 = $time;
      tl0 = $time;
      rises0++;
      acc0 = {acc0[6:0], mosi0};
    end
    prev_sclk0 = sclk0;
  end

  // Monitor 1
  int          rises1 = 0, cslow1 = 0;
  logic        prev_sclk1 = 1'b0;
  longint      tf1 = 0, tl1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      chk("done1_expected", {31'd0, exp1_q.size() != 0}, 32'd1);
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        chk("rx1", 32'(rx1), 32'(e.rx));
        chk("rises1", rises1, 32'd16);
        chk("cs1_low_cycles", cslow1, 32'd34);
        chk("done1_time", 32'($time), 32'(e.t));
        chk("sclk1_span", 32'(tl1 - tf1), 32'd300);
      end
      rises1 = 0; cslow1 = 0;
    end
    if (cs1 != 3'b111) begin
      cslow1++;
      chk("cs1_pattern", 32'(cs1), (exp1_q.size() != 0) ? exp1_q[0].cs : 32'h7);
    end
    if (sclk1 && !prev_sclk1) begin
      if (rises1 == 0) tf1 = $time;
      tl1 = $time;
      rises1++;
    end
    prev_sclk1 = sclk1;
  end

  task automatic go0(input logic [1:0] sel, input logic [7:0] tx, input logic [7:0] sw);
    exp_t e;
    @(negedge clk);
    start0 = 1'b1; sel0 = sel; tx0 = tx;
    slave_q.push_back(sw);
    @(posedge clk);
    e.t = $time + 725; e.rx = 16'(sw); e.tx = 16'(tx);
    e.cs = ~(32'd1 << sel) & 32'hF;
    exp0_q.push_back(e);
    #1 start0 = 1'b0; sel0 = 2'($urandom); tx0 = 8'($urandom);
  endtask

  task automatic go1(input logic [1:0] sel, input logic [15:0] tx);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; sel1 = sel; tx1 = tx;
    @(posedge clk);
    e.t = $time + 345; e.rx = tx; e.tx = tx;
    e.cs = ~(32'd1 << sel) & 32'h7;
    exp1_q.push_back(e);
    #1 start1 = 1'b0; sel1 = 2'($urandom); tx1 = 16'($urandom);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((exp0_q.size() + exp1_q.size()) > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp0_q.size() + exp1_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_cs0", 32'(cs0), 32'hF);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_sclk0", 32'(sclk0), 32'd0);
    chk("rst_rx1", 32'(rx1), 32'd0);
    chk("rst_cs1", 32'(cs1), 32'h7);
    rst0 = 1'b0; rst1 = 1'b0;

    // Directed A5 / 3C transfer to slave 2
    go0(2'd2, 8'hA5, 8'h3C);
    @(negedge clk);
    chk("first_cycle_cs0", 32'(cs0), 32'hB);
    chk("first_cycle_busy0", 32'(busy0), 32'd1);
    chk("first_cycle_mosi0", 32'(mosi0), 32'd1);
    drain(200);
    chk("rx0_held", 32'(rx0), 32'h3C);

    // Slave-select sweep
    for (int s = 0; s < 4; s++) begin
      go0(2'(s), (s % 2 == 0) ? 8'hFF : 8'h00, 8'($urandom));
      drain(200);
    end

    // start during an active transfer is ignored
    go0(2'd1, 8'h96, 8'h69);
    repeat (19) @(negedge clk);
    start0 = 1'b1; sel0 = 2'd3; tx0 = 8'h11;
    @(negedge clk);
    start0 = 1'b0;
    drain(200);

    // Back-to-back with start held through the done cycle
    go0(2'd2, 8'hA5, 8'h3C);
    repeat (72) @(negedge clk);
    start0 = 1'b1; sel0 = 2'd1; tx0 = 8'h5A;
    slave_q.push_back(8'hC3);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done", 32'(done0), 32'd1);
    chk("b2b_gap_cs0", 32'(cs0), 32'hF);
    @(posedge clk);
    e.t = $time + 725; e.rx = 16'h00C3; e.tx = 16'h005A; e.cs = 32'hD;
    exp0_q.push_back(e);
    #1 start0 = 1'b0;
    @(negedge clk);
    chk("b2b_second_cs0", 32'(cs0), 32'hD);
    chk("b2b_second_busy0", 32'(busy0), 32'd1);
    drain(200);

    // Reset mid-transfer
    go0(2'd0, 8'($urandom), 8'($urandom));
    repeat (29) @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1 rst0 = 1'b0;
    @(negedge clk);
    chk("abort_cs0", 32'(cs0), 32'hF);
    chk("abort_sclk0", 32'(sclk0), 32'd0);
    chk("abort_mosi0", 32'(mosi0), 32'd0);
    chk("abort_busy0", 32'(busy0), 32'd0);
    chk("abort_rx0", 32'(rx0), 32'd0);
    exp0_q.delete();
    flush0 = 1'b1;
    repeat (100) @(negedge clk);
    go0(2'd3, 8'hC6, 8'h9D);
    drain(200);

    // Randomized default-instance transfers
    for (int i = 0; i < 6; i++) begin
      go0(2'($urandom), 8'($urandom), 8'($urandom));
      drain(200);
    end

    // Fast instance: loopback, out-of-range select, random words
    go1(2'd0, 16'h8001);
    drain(100);
    chk("rx1_held", 32'(rx1), 32'h8001);
    @(negedge clk);
    start1 = 1'b1; sel1 = 2'd3; tx1 = 16'hFFFF;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("oor_busy1", 32'(busy1), 32'd0);
    chk("oor_cs1", 32'(cs1), 32'h7);
    repeat (50) @(negedge clk);
    chk("oor_rx1", 32'(rx1), 32'h8001);
    for (int i = 0; i < 5; i++) begin
      go1(2'($urandom_range(2, 0)), 16'($urandom));
      drain(100);
    end

    drain(500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
